// File: rtl/peasant_mult_param.sv
// Shift-and-add ("Russian peasant") multiplier. The multiplier operand is halved
// and the multiplicand doubled on each CALC cycle. Two's-complement operands are
// supported by multiplying magnitudes and negating the result.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for in_valid; in_ready=1; mult holds the last result
//   CALC  | one shift/add step per cycle; the cycle with xr==0 registers mult
//   DONE  | out_valid=1, holds mult until out_ready (or abort)
module peasant_mult_param #(
   parameter int WIDTH     = 16,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   input  logic               is_signed,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] mult,
   output logic               busy
);

   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [WIDTH-1:0] xr;
   logic [PW-1:0]   yr;
   logic [PW-1:0]   acc;
   logic            neg;

   logic [WIDTH-1:0] x_mag;
   logic [WIDTH-1:0] y_mag;
   logic             neg_in;
   logic [PW-1:0]    result;

   // Magnitudes fit in WIDTH unsigned bits, including |-2^(WIDTH-1)|.
   generate
      if (SIGNED_EN) begin : g_signed
         logic x_neg;
         logic y_neg;
         always_comb begin
            x_neg  = is_signed & x[WIDTH-1];
            y_neg  = is_signed & y[WIDTH-1];
            x_mag  = x_neg ? -x : x;
            y_mag  = y_neg ? -y : y;
            neg_in = x_neg ^ y_neg;
            result = neg ? -acc : acc;
         end
      end else begin : g_unsigned
         logic unused_sign;
         always_comb begin
            x_mag       = x;
            y_mag       = y;
            neg_in      = 1'b0;
            result      = acc;
            unused_sign = is_signed ^ neg;
         end
      end
   endgenerate

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         xr        <= '0;
         yr        <= '0;
         acc       <= '0;
         neg       <= 1'b0;
         mult      <= '0;
         out_valid <= 1'b0;
      end else if (abort) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  xr    <= x_mag;
                  yr    <= {{WIDTH{1'b0}}, y_mag};
                  acc   <= '0;
                  neg   <= neg_in;
                  state <= CALC;
               end
            end
            CALC: begin
               if (xr != '0) begin
                  if (xr[0]) acc <= acc + yr;
                  xr <= xr >> 1;
                  yr <= yr << 1;
               end else begin
                  mult      <= result;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_peasant_mult_param.sv
// Bench for peasant_mult_param (WIDTH=16, SIGNED_EN=1): directed table, handshake,
// abort and reset sequences, then random operands against an arithmetic model.
module tb_peasant_mult_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x;
   logic [15:0] y;
   logic        is_signed;
   logic        abort;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] mult;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   peasant_mult_param #(.WIDTH(16), .SIGNED_EN(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .is_signed (is_signed),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mult      (mult),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic        sg;
      logic [31:0] exp_mult;
      int          exp_lat;
      string       name;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: product by plain integer arithmetic, latency from bit-length of |x|.
   function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input logic sg);
      longint pa, pb, p;
      pa = sg ? longint'($signed(a)) : longint'(a);
      pb = sg ? longint'($signed(b)) : longint'(b);
      p  = pa * pb;
      return p[31:0];
   endfunction

   function automatic int ref_lat(input logic [15:0] a, input logic sg);
      int m;
      m = (sg && a[15]) ? 65536 - int'(a) : int'(a);
      return $clog2(m + 1) + 1;
   endfunction

   task automatic run_op(input logic [15:0] xa, input logic [15:0] ya, input logic sg,
                         input logic [31:0] em, input int el, input string nm);
      int n;
      chk({nm, "_ready_pre"}, in_ready, 1'b1);
      in_valid  = 1'b1;
      x         = xa;
      y         = ya;
      is_signed = sg;
      tick();
      in_valid  = 1'b0;
      x         = 16'($urandom);
      y         = 16'($urandom);
      is_signed = 1'($urandom);
      chk({nm, "_busy"}, busy, 1'b1);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      chk({nm, "_lat"}, n, el);
      chk({nm, "_mult"}, mult, em);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({nm, "_ov_after"}, out_valid, 1'b0);
      chk({nm, "_ready_after"}, in_ready, 1'b1);
   endtask

   vec_t vecs[$];
   logic [31:0] held;

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      x         = '0;
      y         = '0;
      is_signed = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b0;
      #12;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_mult", mult, 32'h0);
      rst = 1'b1;

      vecs.push_back('{16'd3,    16'd5,    1'b0, 32'h0000000F, 3,  "u3x5"});
      vecs.push_back('{16'hFFF9, 16'd6,    1'b1, 32'hFFFFFFD6, 4,  "sm7x6"});
      vecs.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000, 17, "smin_sq"});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 17, "umax_sq"});
      vecs.push_back('{16'd0,    16'd1234, 1'b0, 32'h00000000, 1,  "zero_x"});
      vecs.push_back('{16'd1234, 16'd0,    1'b1, 32'h00000000, 12, "zero_y"});
      vecs.push_back('{16'hFFFF, 16'd2,    1'b1, 32'hFFFFFFFE, 2,  "sm1x2"});
      vecs.push_back('{16'h8000, 16'd3,    1'b0, 32'h00018000, 17, "u8000x3"});
      vecs.push_back('{16'd5,    16'hFFFD, 1'b1, 32'hFFFFFFF1, 4,  "s5xm3"});
      foreach (vecs[i])
         run_op(vecs[i].x, vecs[i].y, vecs[i].sg, vecs[i].exp_mult, vecs[i].exp_lat, vecs[i].name);

      // DONE held with out_ready low; in_valid pulses must be ignored.
      in_valid = 1'b1; x = 16'd9; y = 16'd9; is_signed = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 40 && !out_valid; i++) tick();
      chk("hold_mult0", mult, 32'd81);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         x = 16'd100;
         tick();
         chk("hold_ov", out_valid, 1'b1);
         chk("hold_mult", mult, 32'd81);
         chk("hold_in_ready", in_ready, 1'b0);
      end
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("hs_ov", out_valid, 1'b0);
      chk("hs_idle", busy, 1'b0);
      tick();
      chk("hs_no_accept", busy, 1'b0);

      // Abort on the 2nd CALC cycle.
      in_valid = 1'b1; x = 16'd255; y = 16'd2; is_signed = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_idle", in_ready, 1'b1);
      chk("abort_ov", out_valid, 1'b0);
      chk("abort_mult", mult, 32'd81);
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | out_valid;
         end
         chk("abort_no_pulse", seen, 1'b0);
      end

      // Reset mid-CALC, then accept on the first edge after release.
      in_valid = 1'b1; x = 16'hFFFF; y = 16'd3; is_signed = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("mrst_ov", out_valid, 1'b0);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_ready", in_ready, 1'b1);
      chk("mrst_mult", mult, 32'h0);
      #3;
      rst = 1'b1;
      run_op(16'd2, 16'd3, 1'b0, 32'd6, 3, "post_rst");

      // Random operands against the arithmetic model.
      for (int i = 0; i < 150; i++) begin
         logic [15:0] ra, rb;
         logic        rs;
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 4 == 0) ra = ra >> $urandom_range(15, 0);
         rs = 1'($urandom);
         run_op(ra, rb, rs, ref_prod(ra, rb, rs), ref_lat(ra, rs), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
